uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of byte requesters (2..8).
REQ-002 Parameter: BUSY_TMO, 15, max cycles ISSUE->tx_busy high before timeout (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester byte pending.
REQ-006 req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i].
REQ-007 req_lock  input  NREQ  per-requester hold-grant request.
REQ-008 req_ready  output  NREQ  one-hot accept strobe, one cycle.
REQ-009 uart_transmit  output  1  start strobe to the UART transmitter.
REQ-010 uart_tx_byte  output  8  byte to the UART transmitter.
REQ-011 uart_tx_busy  input  1  UART transmitter is_transmitting.
REQ-012 grant  output  NREQ  one-hot current owner; zero when idle and unlocked.
REQ-013 arb_busy  output  1  high in any state other than IDLE.
REQ-014 tmo_err  output  1  sticky timeout flag.
REQ-015 err_clr  input  1  clears tmo_err.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if any eligible req_valid, winner chosen round-robin starting at (last_owner+1) mod NREQ; req_ready[winner] high combinationally that cycle; req_data byte latched into uart_tx_byte register; grant set; next state ISSUE.
REQ-018 IDLE with no eligible valid: remain IDLE, req_ready all zero.
REQ-019 ISSUE: uart_transmit high exactly this one cycle; next state WAIT_BUSY.
REQ-020 WAIT_BUSY: uart_tx_busy high -> WAIT_DONE; else count; count reaching BUSY_TMO -> set tmo_err, go IDLE.
REQ-021 WAIT_DONE: uart_tx_busy low -> IDLE, last_owner updated to current owner; grant cleared unless lock held (REQ-030).
REQ-022 uart_tx_byte SHALL stay stable from latch until return to IDLE.
REQ-023 Accept-to-transmit latency: uart_transmit in the cycle after req_ready.
REQ-024 At most one byte outstanding; req_ready never asserts outside IDLE.
REQ-025 err_clr and timeout in same cycle: set wins.
REQ-026 req_valid dropping after accept has no effect on the in-flight byte.
REQ-027 Timeout counter width ceil(log2(BUSY_TMO+1)); cleared on entry to WAIT_BUSY.

Reset
REQ-028 rst SHALL immediately force IDLE, uart_transmit=0, req_ready=0, grant=0, arb_busy=0, tmo_err=0, uart_tx_byte=0, counter=0, last_owner=NREQ-1 (requester 0 first priority), lock cleared.
REQ-029 Reset mid-transfer abandons the byte; no retry after release.

Configuration
REQ-030 Macro UART_ARB_LOCK_EN defined: on exit of WAIT_DONE, if req_lock[owner] high, lock set and only owner eligible in IDLE; grant held; lock released when req_lock[owner] low in IDLE, and normal round-robin resumes that same cycle.
REQ-031 Macro undefined: req_lock ignored, no lock state synthesized, behaviour per REQ-017..021 only.

Verification
REQ-032 Single: req_valid=0001, byte 0x41 -> req_ready=0001 same cycle, uart_transmit next cycle, uart_tx_byte=0x41 until busy falls.
REQ-033 Fairness: all four valid continuously, bytes 0x10..0x13 -> accept order 0,1,2,3,0 after reset.
REQ-034 Timeout: uart_tx_busy tied 0 -> tmo_err set 15 cycles after ISSUE, FSM IDLE; err_clr -> tmo_err 0 next cycle.
REQ-035 Reset mid WAIT_DONE -> all outputs per REQ-028 without clock edge; next request from requester 0 wins over 1.
REQ-036 UART_ARB_LOCK_EN: requester 2 lock high, 3 bytes, requesters 0,1 valid -> three consecutive grants to 2; without macro -> order 2,0,1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among NREQ byte
// requesters. It accepts one byte at a time, starts the transmitter, and
// waits for the transmitter's busy flag to rise and then fall. If busy never
// rises within BUSY_TMO cycles, the transfer is dropped and a sticky error
// is flagged.
//
// Optional feature: define UART_ARB_LOCK_EN to let the current owner keep
// the grant across bytes while it holds req_lock.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   BUSY_TMO  max WAIT_BUSY cycles before timeout (1..255)
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req_valid      [NREQ]    requester i has a byte pending
//   req_data       [8*NREQ]  byte of requester i at [8i+7:8i]
//   req_lock       [NREQ]    requester i asks to keep the grant (lock build only)
//   req_ready      [NREQ]    one-hot accept strobe, combinational in IDLE
//   uart_transmit  one-cycle start strobe to the transmitter
//   uart_tx_byte   [8]       byte to the transmitter, stable until back in IDLE
//   uart_tx_busy   transmitter is sending
//   grant          [NREQ]    one-hot current owner
//   arb_busy       high whenever the FSM is not IDLE
//   tmo_err        sticky busy-timeout flag
//   err_clr        clears tmo_err (a timeout in the same cycle wins)
module uart_tx_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned BUSY_TMO = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_lock,
    output logic [NREQ-1:0]     req_ready,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_tx_busy,
    output logic [NREQ-1:0]     grant,
    output logic                arb_busy,
    output logic                tmo_err,
    input  logic                err_clr
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BUSY_TMO + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_owner;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   cand;
    logic            win_vld;
    logic [NREQ-1:0] win_onehot;
    logic [NREQ-1:0] owner_onehot;
    logic [NREQ-1:0] eligible;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            tmo_hit;
    logic            done;
    logic            lock_hold;

`ifdef UART_ARB_LOCK_EN
    logic lock;

    // Lock only restricts eligibility while the owner still asserts req_lock;
    // dropping req_lock in IDLE reopens round-robin in that same cycle.
    assign lock_hold = lock && req_lock[owner];
`else
    logic unused_req_lock;

    assign lock_hold       = 1'b0;
    assign unused_req_lock = ^req_lock;
`endif

    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
    end

    always_comb begin
        eligible = req_valid;
        if (lock_hold) begin
            eligible = req_valid & owner_onehot;
        end
    end

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        winner  = last_owner;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = OW'((32'(last_owner) + i) % NREQ);
            if (!win_vld && eligible[cand]) begin
                winner  = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        tmo_hit       = 1'b0;
        done          = 1'b0;
        req_ready     = '0;
        uart_transmit = 1'b0;
        arb_busy      = 1'b1;
        case (state)
            IDLE: begin
                arb_busy = 1'b0;
                // Gated by rst so the strobe is low the instant reset asserts,
                // even while requesters keep req_valid high.
                if (win_vld && !rst) begin
                    req_ready = win_onehot;
                end
                if (win_vld) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                uart_transmit = 1'b1;
                state_nx      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (cnt_inc == CW'(BUSY_TMO)) begin
                    tmo_hit  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= '0;
            last_owner   <= OW'(NREQ - 1);
            grant        <= '0;
            uart_tx_byte <= '0;
            cnt          <= '0;
            tmo_err      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (lock && !req_lock[owner]) begin
                        lock <= 1'b0;
                    end
`endif
                    if (win_vld) begin
                        owner        <= winner;
                        grant        <= win_onehot;
                        uart_tx_byte <= req_data[{winner, 3'b000} +: 8];
                    end else if (!lock_hold) begin
                        grant <= '0;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (!uart_tx_busy) begin
                        cnt <= cnt_inc;
                    end
                    // A timed-out transfer gives up ownership entirely,
                    // including any lock; last_owner is left untouched.
                    if (tmo_hit) begin
                        grant <= '0;
`ifdef UART_ARB_LOCK_EN
                        lock  <= 1'b0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        last_owner <= owner;
`ifdef UART_ARB_LOCK_EN
                        lock <= req_lock[owner];
                        if (!req_lock[owner]) begin
                            grant <= '0;
                        end
`else
                        grant <= '0;
`endif
                    end
                end
                default: begin
                end
            endcase

            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end else if (err_clr) begin
                tmo_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4, BUSY_TMO=15).
// Requesters are modelled as per-requester byte FIFOs; the expected accept
// order is pushed to a scoreboard as stimulus is loaded, and popped whenever
// the DUT strobes req_ready. A small transmitter model raises busy two cycles
// after each start strobe and holds it for four cycles.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int BUSY_TMO = 15;
    localparam int DEPTH    = 8;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ-1:0]     req_ready;
    logic                uart_transmit;
    logic [7:0]          uart_tx_byte;
    logic                uart_tx_busy;
    logic [NREQ-1:0]     grant;
    logic                arb_busy;
    logic                tmo_err;
    logic                err_clr;

    uart_tx_arbiter #(
        .NREQ     (NREQ),
        .BUSY_TMO (BUSY_TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_lock      (req_lock),
        .req_ready     (req_ready),
        .uart_transmit (uart_transmit),
        .uart_tx_byte  (uart_tx_byte),
        .uart_tx_busy  (uart_tx_busy),
        .grant         (grant),
        .arb_busy      (arb_busy),
        .tmo_err       (tmo_err),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t            exp_q[$];
    logic [7:0]      src_buf[NREQ][DEPTH];
    int              src_rd[NREQ];
    int              src_wr[NREQ];
    logic [NREQ-1:0] lock_want;

    int         n_cmp;
    int         n_err;
    bit         tx_due;
    int         pend_idx;
    logic [7:0] pend_byte;
    logic [NREQ-1:0] last_ready;
    logic       saw_tx;
    logic       mon_tmo;
    logic       mon_arb;
    logic       mon_ubusy;
    bit         uart_en;
    int         uart_dly;
    int         uart_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit pending_src();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = src_buf[i][src_rd[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
            req_lock[i] = lock_want[i] && (src_rd[i] < src_wr[i]);
        end
    endtask

    task automatic push_src(input int i, input logic [7:0] b);
        src_buf[i][src_wr[i]] = b;
        src_wr[i]++;
    endtask

    task automatic push_exp(input int i, input logic [7:0] b);
        exp_t e;
        e.idx  = i;
        e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        exp_q.delete();
        lock_want    = '0;
        tx_due       = 1'b0;
        uart_tx_busy = 1'b0;
        uart_dly     = 0;
        uart_len     = 0;
        uart_en      = 1'b1;
        err_clr      = 1'b0;
        drive_reqs();
    endtask

    // One clock: sample and score at negedge, then update requesters and the
    // transmitter model just after the rising edge.
    task automatic step();
        int   acc;
        exp_t e;
        acc = -1;
        @(negedge clk);
        last_ready = req_ready;
        saw_tx     = uart_transmit;
        mon_tmo    = tmo_err;
        mon_arb    = arb_busy;
        mon_ubusy  = uart_tx_busy;
        if (tx_due) begin
            check("tx_strobe", uart_transmit, 1);
            check("tx_byte", uart_tx_byte, pend_byte);
            check("tx_grant", grant, 32'(1) << pend_idx);
            tx_due = 1'b0;
        end else if (uart_transmit) begin
            check("tx_spurious", uart_transmit, 0);
        end else if (arb_busy) begin
            check("byte_stable", uart_tx_byte, pend_byte);
        end
        if (req_ready != '0) begin
            check("ready_onehot", $countones(req_ready), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) acc = i;
            end
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("accept_idx", acc, e.idx);
                check("accept_byte", req_data[8*acc +: 8], e.data);
            end
            pend_idx  = acc;
            pend_byte = req_data[8*acc +: 8];
            tx_due    = 1'b1;
        end
        @(posedge clk);
        #1;
        if (acc >= 0 && src_rd[acc] < src_wr[acc]) src_rd[acc]++;
        if (!uart_en) begin
            uart_tx_busy = 1'b0;
            uart_dly     = 0;
        end else if (saw_tx) begin
            uart_dly = 2;
        end else if (uart_dly > 0) begin
            uart_dly--;
            if (uart_dly == 0) begin
                uart_tx_busy = 1'b1;
                uart_len     = 4;
            end
        end else if (uart_tx_busy) begin
            uart_len--;
            if (uart_len == 0) uart_tx_busy = 1'b0;
        end
        drive_reqs();
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((pending_src() || exp_q.size() != 0 || arb_busy || uart_tx_busy) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drain"}, n < budget, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp     = 0;
        n_err     = 0;
        pend_idx  = 0;
        pend_byte = 8'h00;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        rst       = 1'b1;
        clear_bench();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_transmit", uart_transmit, 0);
        check("rst_grant", grant, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_tmo", tmo_err, 0);
        check("rst_byte", uart_tx_byte, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte from requester 0
        push_src(0, 8'h41);
        push_exp(0, 8'h41);
        drive_reqs();
        step();
        check("single_ready", last_ready, 4'b0001);
        step();
        check("single_tx_next", saw_tx, 1);
        drain(60, "single");
        check("single_grant_idle", grant, 0);

        // Fairness: all four valid, requester 0 has a second byte
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push_src(i, 8'(8'h10 + i));
            push_exp(i, 8'(8'h10 + i));
        end
        push_src(0, 8'h10);
        push_exp(0, 8'h10);
        drive_reqs();
        drain(200, "fair");

        // Busy never rises: timeout, set beats a simultaneous clear
        uart_en = 1'b0;
        push_src(1, 8'h5A);
        push_exp(1, 8'h5A);
        drive_reqs();
        n = 0;
        do begin
            step();
            n++;
        end while (!saw_tx && n < 10);
        check("tmo_issue_seen", saw_tx, 1);
        for (int k = 1; k <= BUSY_TMO + 1; k++) begin
            step();
            if (k == BUSY_TMO - 1) err_clr = 1'b1;
            if (k == BUSY_TMO) begin
                check("tmo_early", mon_tmo, 0);
                check("tmo_wait_busy", mon_arb, 1);
                err_clr = 1'b0;
            end
        end
        check("tmo_set", mon_tmo, 1);
        check("tmo_idle", mon_arb, 0);
        err_clr = 1'b1;
        step();
        check("tmo_sticky", mon_tmo, 1);
        err_clr = 1'b0;
        step();
        check("tmo_clr", mon_tmo, 0);
        uart_en = 1'b1;

        // Requester 2 with lock request and three bytes, 0 and 1 join later
        do_reset();
        lock_want = 4'b0100;
        push_src(2, 8'hA0);
        push_src(2, 8'hA1);
        push_src(2, 8'hA2);
        push_exp(2, 8'hA0);
        drive_reqs();
        n = 0;
        do begin
            step();
            n++;
        end while (last_ready == '0 && n < 10);
        check("lock_first_accept", last_ready, 4'b0100);
        push_src(0, 8'hB0);
        push_src(1, 8'hB1);
`ifdef UART_ARB_LOCK_EN
        push_exp(2, 8'hA1);
        push_exp(2, 8'hA2);
        push_exp(0, 8'hB0);
        push_exp(1, 8'hB1);
`else
        push_exp(0, 8'hB0);
        push_exp(1, 8'hB1);
        push_exp(2, 8'hA1);
        push_exp(2, 8'hA2);
`endif
        drive_reqs();
        drain(400, "lock");
        check("lock_grant_idle", grant, 0);
        lock_want = '0;
        drive_reqs();

        // Reset while waiting for busy to fall; last_owner is 0 beforehand
        push_src(0, 8'h66);
        push_exp(0, 8'h66);
        drive_reqs();
        drain(60, "pre_rst");
        push_src(0, 8'h77);
        push_exp(0, 8'h77);
        drive_reqs();
        n = 0;
        do begin
            step();
            n++;
        end while (!mon_ubusy && n < 20);
        step();
        check("pre_rst_busy", arb_busy, 1);
        check("pre_rst_byte", uart_tx_byte, 8'h77);
        push_src(0, 8'hC0);
        push_src(1, 8'hC1);
        drive_reqs();
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", req_ready, 0);
        check("arst_transmit", uart_transmit, 0);
        check("arst_grant", grant, 0);
        check("arst_arb_busy", arb_busy, 0);
        check("arst_tmo", tmo_err, 0);
        check("arst_byte", uart_tx_byte, 0);
        exp_q.delete();
        tx_due       = 1'b0;
        uart_tx_busy = 1'b0;
        uart_dly     = 0;
        push_exp(0, 8'hC0);
        push_exp(1, 8'hC1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(200, "post_rst");
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
